dance_pattern_sequencer: RTL and testbench
==========================================

Name: dance_pattern_sequencer

Overview:
Produces the arrow-pattern stream consumed by the score tracker: pattern_a, pattern_b, pattern_valid, pattern_timer, game_active and game_over. It paces a game as a fixed number of timed hit windows separated by gaps. Arrows come from an on-chip 16-bit LFSR. It sits between the game-control front end (start, pause and abort buttons) and the score system.

Parameters:
WINDOW_CYCLES, 500000, length of each hit window in clocks (1..2^20)
GAP_CYCLES, 250000, idle clocks between windows (0 allowed = back-to-back)
NUM_PATTERNS, 32, windows per game (1..255)
LFSR_SEED, 16'hACE1, LFSR reset value (0 is forced to 16'h0001)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
game_start  in  1  single-cycle pulse; starts a game from IDLE or DONE
game_pause  in  1  level; freezes all counters while high
game_abort  in  1  single-cycle pulse; returns to IDLE without game_over
game_active  out  1  high from first window start until the last window ends
game_over  out  1  high in DONE
pattern_a  out  4  one-hot arrow for player A, 0 outside windows
pattern_b  out  4  one-hot arrow for player B, 0 outside windows
pattern_valid  out  1  high during a hit window
pattern_timer  out  20  clocks elapsed in the current window, 0 outside windows
pattern_index  out  8  number of completed windows in the current game

Behaviour:
- One clock domain: clock. reset is asynchronous and active-high.
- Reset values:
  - state = IDLE; every output = 0.
  - lfsr = LFSR_SEED, or 1 if the seed is 0.
  - Internal gap counter = 0.
- Arrow encoding: code 00=UP 4'b0001, 01=DOWN 4'b0010, 10=LEFT 4'b0100, 11=RIGHT 4'b1000.
  - pattern_a = 1 << lfsr[1:0].
  - pattern_b = 1 << lfsr[3:2].
  - Both are sampled at window load.
- LFSR: Fibonacci shift-left.
  - new_bit = l[15]^l[13]^l[12]^l[10]; l <= {l[14:0], new_bit}.
  - Advances exactly once per window load, on the same edge that loads the window.
  - Not reseeded between games; only reset reloads the seed.
- States: IDLE, ACTIVE, GAP, DONE.
- IDLE:
  - game_start loads a window on the next edge: pattern_valid=1, pattern_timer=0, arrows from the current lfsr, game_active=1, pattern_index=0.
- ACTIVE:
  - pattern_timer increments by 1 per unpaused clock.
  - On the edge where pattern_timer == WINDOW_CYCLES-1, pattern_index increments, then:
    - If this was the last window (index reaches NUM_PATTERNS): go to DONE. pattern_valid=0, arrows=0, timer=0, game_active=0, game_over=1.
    - Else if GAP_CYCLES == 0: reload directly. pattern_valid stays 1, timer=0, new arrows.
    - Else: go to GAP. pattern_valid=0, arrows=0, timer=0.
- GAP:
  - The gap counter increments per unpaused clock.
  - When it reaches GAP_CYCLES-1, the next edge loads a window (same as from IDLE, without clearing the index) and clears the gap counter.
- DONE:
  - game_over is held high.
  - game_start clears game_over, resets pattern_index to 0 and loads a window on the same edge.
- game_start is ignored in ACTIVE and GAP.
- game_pause: while high, pattern_timer and the gap counter hold, all outputs hold, and no transitions occur.
  - game_abort still acts during pause.
- game_abort in ACTIVE or GAP: next edge goes to IDLE with all outputs 0 and no game_over.
  - Abort in IDLE or DONE is ignored.
  - Abort and start in the same cycle: abort wins (start ignored).
- An asynchronous reset mid-game clears everything immediately, including the LFSR.
- Window timing with no pause:
  - Each window holds pattern_valid for exactly WINDOW_CYCLES clocks.
  - Each gap holds pattern_valid low for exactly GAP_CYCLES clocks.
  - game_active lasts NUM_PATTERNS*WINDOW_CYCLES + (NUM_PATTERNS-1)*GAP_CYCLES clocks.

Test Plan:
1. Reset mid-window (WINDOW_CYCLES=8, GAP_CYCLES=4, NUM_PATTERNS=3, seed ACE1): assert reset at timer=5 -> all outputs 0 asynchronously, before the next edge. After release, the first window again shows pattern_a=4'b0010, pattern_b=4'b0001.
2. Full game, same parameters: start pulse -> valid high 8 clocks (timer 0..7), low 4, high 8, low 4, high 8.
   - Arrows per window: (a=0010, b=0001), then (a=1000, b=0001) from lfsr 59C3, then the next LFSR step.
   - game_active high 32 clocks; game_over=1 and pattern_index=3 after.
3. Pause: pause held 5 clocks at timer=3 -> timer stays 3, valid stays 1. Window total = 13 clocks of valid.
4. Abort in GAP -> IDLE next edge, game_over=0, outputs 0. A start pulse two cycles later begins a new game at index 0 with the LFSR continuing (not seed).
5. GAP_CYCLES=0: valid never deasserts between windows; timer wraps 7->0 and arrows change on the same edge. 24 valid clocks total.
6. Simultaneous start+abort in ACTIVE -> IDLE. Start in ACTIVE alone -> ignored (timer continues).

Source files
------------

// File: rtl/dance_pattern_sequencer.sv
// Purpose: paces a game as NUM_PATTERNS timed hit windows separated by gaps, with LFSR-drawn arrows.
// Latency: a start pulse loads the first window on the next clock edge; all outputs are registered.
// Backpressure: none downstream; game_pause freezes counters and outputs, and game_abort still acts while paused.
module dance_pattern_sequencer #(
    parameter int unsigned WINDOW_CYCLES = 500000,
    parameter int unsigned GAP_CYCLES    = 250000,
    parameter int unsigned NUM_PATTERNS  = 32,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        game_start,
    input  logic        game_pause,
    input  logic        game_abort,
    output logic        game_active,
    output logic        game_over,
    output logic [3:0]  pattern_a,
    output logic [3:0]  pattern_b,
    output logic        pattern_valid,
    output logic [19:0] pattern_timer,
    output logic [7:0]  pattern_index
);

    // Terminal counts as 20/8-bit constants so the compares are width-matched.
    localparam logic [19:0] WIN_LAST = 20'(WINDOW_CYCLES - 1);
    localparam logic [19:0] GAP_LAST = 20'(GAP_CYCLES - 1);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_PATTERNS - 1);
    localparam bit          NO_GAP   = (GAP_CYCLES == 0);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] lfsr;
    logic [15:0] lfsr_n;
    logic [15:0] lfsr_step;
    logic [19:0] gap_cnt;
    logic [19:0] gap_cnt_n;
    logic [19:0] timer_n;
    logic [7:0]  index_n;
    logic [3:0]  a_n;
    logic [3:0]  b_n;
    logic        valid_n;
    logic        active_n;
    logic        over_n;
    logic        load;
    logic        clear;
    logic        start_ok;

    // Fibonacci shift-left step; only committed on the edge that loads a window.
    assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // A start is honoured only when not paused and not overridden by a same-cycle abort.
    assign start_ok = game_start && !game_abort && !game_pause;

    // State and output registers; reset clears everything immediately, including the LFSR.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            lfsr          <= SEED_EFF;
            gap_cnt       <= 20'd0;
            pattern_timer <= 20'd0;
            pattern_index <= 8'd0;
            pattern_a     <= 4'd0;
            pattern_b     <= 4'd0;
            pattern_valid <= 1'b0;
            game_active   <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state         <= state_n;
            lfsr          <= lfsr_n;
            gap_cnt       <= gap_cnt_n;
            pattern_timer <= timer_n;
            pattern_index <= index_n;
            pattern_a     <= a_n;
            pattern_b     <= b_n;
            pattern_valid <= valid_n;
            game_active   <= active_n;
            game_over     <= over_n;
        end
    end

    // Next-state and next-output logic; everything holds unless a branch below changes it.
    always_comb begin
        state_n   = state;
        lfsr_n    = lfsr;
        gap_cnt_n = gap_cnt;
        timer_n   = pattern_timer;
        index_n   = pattern_index;
        a_n       = pattern_a;
        b_n       = pattern_b;
        valid_n   = pattern_valid;
        active_n  = game_active;
        over_n    = game_over;
        load      = 1'b0;
        clear     = 1'b0;

        case (state)
            IDLE: begin
                if (start_ok) begin
                    index_n = 8'd0;
                    load    = 1'b1;
                end
            end
            ACTIVE: begin
                if (game_abort) begin
                    state_n   = IDLE;
                    clear     = 1'b1;
                    index_n   = 8'd0;
                    active_n  = 1'b0;
                    over_n    = 1'b0;
                    gap_cnt_n = 20'd0;
                end else if (!game_pause) begin
                    if (pattern_timer == WIN_LAST) begin
                        index_n = pattern_index + 8'd1;
                        if (pattern_index == LAST_IDX) begin
                            state_n  = DONE;
                            clear    = 1'b1;
                            active_n = 1'b0;
                            over_n   = 1'b1;
                        end else if (NO_GAP) begin
                            load = 1'b1;
                        end else begin
                            state_n   = GAP;
                            clear     = 1'b1;
                            gap_cnt_n = 20'd0;
                        end
                    end else begin
                        timer_n = pattern_timer + 20'd1;
                    end
                end
            end
            GAP: begin
                if (game_abort) begin
                    state_n   = IDLE;
                    clear     = 1'b1;
                    index_n   = 8'd0;
                    active_n  = 1'b0;
                    over_n    = 1'b0;
                    gap_cnt_n = 20'd0;
                end else if (!game_pause) begin
                    if (gap_cnt == GAP_LAST) begin
                        load = 1'b1;
                    end else begin
                        gap_cnt_n = gap_cnt + 20'd1;
                    end
                end
            end
            DONE: begin
                if (start_ok) begin
                    index_n = 8'd0;
                    over_n  = 1'b0;
                    load    = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                clear   = 1'b1;
            end
        endcase

        if (clear) begin
            valid_n = 1'b0;
            timer_n = 20'd0;
            a_n     = 4'd0;
            b_n     = 4'd0;
        end

        if (load) begin
            state_n   = ACTIVE;
            valid_n   = 1'b1;
            timer_n   = 20'd0;
            a_n       = 4'b0001 << lfsr[1:0];
            b_n       = 4'b0001 << lfsr[3:2];
            active_n  = 1'b1;
            lfsr_n    = lfsr_step;
            gap_cnt_n = 20'd0;
        end
    end

endmodule

// File: tb/tb_dance_pattern_sequencer.sv
// Purpose: scoreboard bench for dance_pattern_sequencer with gapped and back-to-back window instances.
// Latency: expected window samples are queued before each start; monitors pop one per valid clock.
// Backpressure: none; pause and abort are driven directly by the stimulus process.
module tb_dance_pattern_sequencer;

    typedef struct packed {
        logic [3:0]  a;
        logic [3:0]  b;
        logic [19:0] timer;
        logic [7:0]  idx;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start0, pause0, abort0;
    logic        start1, pause1, abort1;
    logic        active0, over0, valid0;
    logic        active1, over1, valid1;
    logic [3:0]  a0, b0, a1, b1;
    logic [19:0] timer0, timer1;
    logic [7:0]  index0, index1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    // Hand-computed LFSR states from seed ACE1, one per window load.
    logic [15:0] lt [0:5] = '{16'hACE1, 16'h59C3, 16'hB387, 16'h670F, 16'hCE1E, 16'h9C3C};

    always #5 clock = ~clock;

    dance_pattern_sequencer #(
        .WINDOW_CYCLES(8), .GAP_CYCLES(4), .NUM_PATTERNS(3), .LFSR_SEED(16'hACE1)
    ) dut0 (
        .clock(clock), .reset(reset),
        .game_start(start0), .game_pause(pause0), .game_abort(abort0),
        .game_active(active0), .game_over(over0),
        .pattern_a(a0), .pattern_b(b0), .pattern_valid(valid0),
        .pattern_timer(timer0), .pattern_index(index0)
    );

    dance_pattern_sequencer #(
        .WINDOW_CYCLES(8), .GAP_CYCLES(0), .NUM_PATTERNS(3), .LFSR_SEED(16'hACE1)
    ) dut1 (
        .clock(clock), .reset(reset),
        .game_start(start1), .game_pause(pause1), .game_abort(abort1),
        .game_active(active1), .game_over(over1),
        .pattern_a(a1), .pattern_b(b1), .pattern_valid(valid1),
        .pattern_timer(timer1), .pattern_index(index1)
    );

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic exp_t mk(input logic [15:0] l, input int t, input int idx);
        exp_t e;
        e.a     = 4'b0001 << l[1:0];
        e.b     = 4'b0001 << l[3:2];
        e.timer = 20'(t);
        e.idx   = 8'(idx);
        return e;
    endfunction

    // Monitor for the gapped instance: every valid clock must match the next queued sample.
    always @(negedge clock) begin
        if (!reset && valid0) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_valid", {a0, b0, timer0, index0}, 36'h0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("dut0_window_sample", {a0, b0, timer0, index0}, e);
            end
        end
    end

    // Monitor for the back-to-back instance.
    always @(negedge clock) begin
        if (!reset && valid1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_valid", {a1, b1, timer1, index1}, 36'h0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_window_sample", {a1, b1, timer1, index1}, e);
            end
        end
    end

    initial begin
        int cnt;
        reset  = 1'b1;
        start0 = 1'b0; pause0 = 1'b0; abort0 = 1'b0;
        start1 = 1'b0; pause1 = 1'b0; abort1 = 1'b0;
        cyc(2);

        // Reset state.
        chk("rst_valid",  36'(valid0), 36'h0);
        chk("rst_arrows", 36'({a0, b0}), 36'h0);
        chk("rst_timer",  36'(timer0), 36'h0);
        chk("rst_index",  36'(index0), 36'h0);
        chk("rst_active", 36'(active0), 36'h0);
        chk("rst_over",   36'(over0), 36'h0);
        reset = 1'b0;
        cyc(1);

        // Reset asserted mid-window at timer 5 clears outputs before the next edge.
        for (int t = 0; t < 5; t++) q0.push_back(mk(lt[0], t, 0));
        start0 = 1'b1; cyc(1); start0 = 1'b0;
        cyc(5);
        chk("pre_reset_timer", 36'(timer0), 36'd5);
        reset = 1'b1;
        #1;
        chk("async_rst_valid",  36'(valid0), 36'h0);
        chk("async_rst_arrows", 36'({a0, b0}), 36'h0);
        chk("async_rst_timer",  36'(timer0), 36'h0);
        chk("async_rst_active", 36'(active0), 36'h0);
        cyc(1);
        reset = 1'b0;
        cyc(1);

        // Full game: three windows from reloaded seed, gaps of 4.
        for (int w = 0; w < 3; w++)
            for (int t = 0; t < 8; t++) q0.push_back(mk(lt[w], t, w));
        start0 = 1'b1; cyc(1); start0 = 1'b0;
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (active0) cnt++;
            else break;
        end
        chk("game_active_len", 36'(cnt), 36'd32);
        chk("done_over",  36'(over0), 36'd1);
        chk("done_index", 36'(index0), 36'd3);
        chk("done_valid", 36'(valid0), 36'd0);

        // Start from DONE; pause 5 clocks at timer 3 stretches the window to 13 valid clocks.
        for (int t = 0; t < 4; t++) q0.push_back(mk(lt[3], t, 0));
        for (int k = 0; k < 5; k++) q0.push_back(mk(lt[3], 3, 0));
        for (int t = 4; t < 8; t++) q0.push_back(mk(lt[3], t, 0));
        start0 = 1'b1; cyc(1); start0 = 1'b0;
        chk("restart_over",  36'(over0), 36'd0);
        chk("restart_index", 36'(index0), 36'd0);
        cyc(3);
        pause0 = 1'b1;
        cyc(5);
        chk("paused_timer", 36'(timer0), 36'd3);
        chk("paused_valid", 36'(valid0), 36'd1);
        pause0 = 1'b0;
        cyc(6);

        // Abort during the gap returns to IDLE with no game_over.
        chk("gap_valid",  36'(valid0), 36'd0);
        chk("gap_active", 36'(active0), 36'd1);
        abort0 = 1'b1; cyc(1); abort0 = 1'b0;
        chk("abort_over",   36'(over0), 36'd0);
        chk("abort_active", 36'(active0), 36'd0);
        chk("abort_outs",   36'({a0, b0, timer0, index0}), 36'h0);
        cyc(1);

        // New game continues the LFSR; start alone is ignored, start+abort aborts.
        for (int t = 0; t < 5; t++) q0.push_back(mk(lt[4], t, 0));
        start0 = 1'b1; cyc(1); start0 = 1'b0;
        cyc(2);
        start0 = 1'b1; cyc(1); start0 = 1'b0;
        chk("ignored_start_timer", 36'(timer0), 36'd3);
        cyc(1);
        start0 = 1'b1; abort0 = 1'b1; cyc(1); start0 = 1'b0; abort0 = 1'b0;
        chk("start_abort_valid",  36'(valid0), 36'd0);
        chk("start_abort_active", 36'(active0), 36'd0);
        chk("start_abort_over",   36'(over0), 36'd0);

        // Back-to-back windows: valid held for 24 clocks, arrows change at each wrap.
        for (int w = 0; w < 3; w++)
            for (int t = 0; t < 8; t++) q1.push_back(mk(lt[w], t, w));
        start1 = 1'b1; cyc(1); start1 = 1'b0;
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (valid1) cnt++;
            else break;
        end
        chk("nogap_valid_len", 36'(cnt), 36'd24);
        chk("nogap_over",  36'(over1), 36'd1);
        chk("nogap_index", 36'(index1), 36'd3);

        cyc(2);
        chk("dut0_queue_drained", 36'(q0.size()), 36'd0);
        chk("dut1_queue_drained", 36'(q1.size()), 36'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
